norm_lzc_pipe: RTL

Parametrised, pipelined leading-zero counter and normaliser for the add/sub datapath. It takes the raw adder result, counts leading zeros with per-group local counters, and clamps the shift to a caller-supplied limit so that denormal results stop at the minimum exponent. It then emits the left-shifted, normalised mantissa. The block sits between the adder and the rounding stage, with a valid/ready handshake on both sides and a sideband tag carried alongside the data.

---
 rtl/fpu_norm_pkg.sv | 22 ++
 rtl/norm_lzc_pipe_lzc_group.sv | 16 +
 rtl/norm_lzc_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/fpu_norm_pkg.sv
// fpu_norm_pkg: shared defaults, count helper and stage-1 payload types for the normaliser.
package fpu_norm_pkg;
  localparam int WIDTH_D = 24;
  localparam int GROUP_D = 6;
  localparam int TAG_W_D = 9;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int CW_D = clog2(WIDTH_D + 1);
  localparam int NG_D = WIDTH_D / GROUP_D;
  localparam int GW_D = clog2(GROUP_D);
  typedef logic [CW_D-1:0] countT;
  typedef struct packed {
    logic [NG_D-1:0]           allz;
    logic [NG_D-1:0][GW_D-1:0] lcnt;
    logic [WIDTH_D-1:0]        data;
    countT                     limit;
    logic [TAG_W_D-1:0]        tag;
  } s1PayloadT;
endpackage

// File: rtl/norm_lzc_pipe_lzc_group.sv
// lzc_group: combinational local leading-zero counter for one group of bits.
module lzc_group import fpu_norm_pkg::*; #(
  parameter int GROUP = GROUP_D,
  localparam int GW = GROUP > 1 ? clog2(GROUP) : 1
) (
  input  logic [GROUP-1:0] bits,
  output logic             allz,
  output logic [GW-1:0]    lcnt
);
  assign allz = ~|bits;
  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    lcnt = '0;
    for (int i = 0; i < GROUP; i++) if (bits[i]) lcnt = GW'(GROUP - 1 - i);
  end
endmodule

// File: rtl/norm_lzc_pipe.sv
// norm_lzc_pipe: two-stage leading-zero count and limit-clamped left normaliser
// with valid/ready handshake on both sides and a pass-through tag.
module norm_lzc_pipe import fpu_norm_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int GROUP = GROUP_D,
  parameter int TAG_W = TAG_W_D,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_limit,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_shift,
  output logic             out_zero,
  output logic             out_limited,
  output logic [TAG_W-1:0] out_tag
);
  localparam int NG = WIDTH / GROUP;
  localparam int GW = GROUP > 1 ? clog2(GROUP) : 1;
  if (WIDTH % GROUP != 0) begin : gBadWidth
    $error("norm_lzc_pipe: WIDTH must be a multiple of GROUP");
  end
  typedef struct packed {
    logic [NG-1:0]         allz;
    logic [NG-1:0][GW-1:0] lcnt;
    logic [WIDTH-1:0]      data;
    logic [CW-1:0]         limit;
    logic [TAG_W-1:0]      tag;
  } s1T;
  logic [NG-1:0]         allz;
  logic [NG-1:0][GW-1:0] lcnt;
  logic [CW-1:0]         limC, lzc, shift;
  logic                  s1Valid, s2Load, s1Advance;
  s1T                    s1;
  for (genvar g = 0; g < NG; g++) begin : gGrp
    lzc_group #(.GROUP(GROUP)) uGrp (
      .bits(in_data[g*GROUP +: GROUP]),
      .allz(allz[g]),
      .lcnt(lcnt[g])
    );
  end
  assign limC      = in_limit > CW'(WIDTH) ? CW'(WIDTH) : in_limit;
  assign s2Load    = !out_valid || out_ready;
  assign s1Advance = s1Valid && s2Load;
  assign in_ready  = !s1Valid || s1Advance;
  // Later (more significant) non-zero groups override earlier ones.
  always_comb begin
    lzc = CW'(WIDTH);
    for (int g = 0; g < NG; g++)
      if (!s1.allz[g]) lzc = CW'((NG - 1 - g) * GROUP) + CW'(s1.lcnt[g]);
    shift = lzc < s1.limit ? lzc : s1.limit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid     <= 1'b0;
      s1          <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_shift   <= '0;
      out_zero    <= 1'b0;
      out_limited <= 1'b0;
      out_tag     <= '0;
    end else begin
      if (in_ready) s1Valid <= in_valid;
      if (in_valid && in_ready) s1 <= {allz, lcnt, in_data, limC, in_tag};
      if (s2Load) out_valid <= s1Valid;
      if (s1Advance) begin
        out_data    <= s1.data << shift;
        out_shift   <= shift;
        out_zero    <= &s1.allz;
        out_limited <= (s1.limit < lzc) && !(&s1.allz);
        out_tag     <= s1.tag;
      end
    end
  end
endmodule
